// File: rtl/lut_neuron_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : lut_neuron_cfg_loader
// Description : Runtime-writable LUT neuron. A config stream fills a
//               2^IN_BITS x OUT_BITS truth table (distributed RAM). Once the
//               whole table has been loaded, registered lookups are served
//               with the lookup input used as the table address.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               cfg_start         - pulse, begins a (re)load from beat 0
//               cfg_valid/ready   - config beat handshake (ready in LOAD)
//               cfg_data          - CFG_W-bit config beat
//               cfg_done          - level, complete table resident
//               in_valid/in_data  - lookup request / address
//               out_valid/data    - lookup result, one cycle after request
//               lookup_miss       - pulse, request dropped (table not ready)
// Revision    : 1.0 - initial release
// ============================================================================
module lut_neuron_cfg_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_done,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                lookup_miss
);

    localparam int c_T    = (1 << IN_BITS) * OUT_BITS;
    localparam int c_B    = c_T / CFG_W;
    localparam int c_CW   = (c_B > 1) ? $clog2(c_B) : 1;
    localparam int c_IDXW = $clog2(c_T) + 1;

    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_B - 1);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_READY = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_cnt_nxt;
    logic                w_accept;
    logic                w_hit;
    logic [c_IDXW-1:0]   w_wr_base;
    logic [c_IDXW-1:0]   w_rd_base;

    // Flat truth table; deliberately not reset so it maps onto LUT RAM.
    logic [c_T-1:0]      r_table;

    // Status flags decode straight from the state register, so an
    // asynchronous reset drops them immediately.
    assign cfg_ready = (r_state == c_LOAD);
    assign cfg_done  = (r_state == c_READY);

    assign w_hit     = in_valid && (r_state == c_READY);
    assign w_wr_base = c_IDXW'(r_cnt) * c_IDXW'(CFG_W);
    assign w_rd_base = c_IDXW'(in_data) * c_IDXW'(OUT_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_EMPTY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A restart outranks a beat presented in the same cycle: that beat is
    // dropped and the load begins again from beat 0. On the final beat the
    // counter is held rather than wrapped.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        if (cfg_start) begin
            w_state_nxt = c_LOAD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_LOAD: begin
                    if (cfg_valid) begin
                        w_accept = 1'b1;
                        if (r_cnt == c_LAST) begin
                            w_state_nxt = c_READY;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                c_EMPTY, c_READY: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = c_EMPTY;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_table[w_wr_base +: CFG_W] <= cfg_data;
        end
    end

    // A lookup in the same cycle as a restart from READY still reads the old
    // table, because the state is READY during that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            lookup_miss <= 1'b0;
        end else begin
            out_valid   <= w_hit;
            lookup_miss <= in_valid && !w_hit;
            if (w_hit) begin
                out_data <= r_table[w_rd_base +: OUT_BITS];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_neuron_cfg_loader
// Description : Self-checking bench for lut_neuron_cfg_loader. A behavioural
//               model (table array plus loaded/loading flags) predicts every
//               cycle; table-driven lookup vectors and directed sequences
//               cover the load, restart and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_neuron_cfg_loader;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 1;
    localparam int CFG_W    = 8;
    localparam int c_T      = (1 << IN_BITS) * OUT_BITS;
    localparam int c_B      = c_T / CFG_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_start = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data = '0;
    logic                cfg_done;
    logic                in_valid = 1'b0;
    logic [IN_BITS-1:0]  in_data = '0;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
    logic                lookup_miss;

    lut_neuron_cfg_loader #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .CFG_W    (CFG_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_done    (cfg_done),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .lookup_miss (lookup_miss)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: table contents, beats received so far, and two
    // flags saying whether a load is in progress / a full table is resident.
    bit   m_tbl [c_T];
    int   m_beats;
    bit   m_loading;
    bit   m_done;
    logic m_ov;
    logic m_miss;
    logic m_od;

    typedef struct {
        logic [7:0] addr;
        logic       exp;
    } vec_t;

    vec_t vec_a5 [4];
    vec_t vec_k  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_beats   = 0;
        m_loading = 0;
        m_done    = 0;
        m_ov      = 1'b0;
        m_miss    = 1'b0;
        m_od      = 1'b0;
    endtask

    // One clock cycle: drive inputs on the falling edge, advance the model on
    // the rules of the block, then compare all outputs just after the rising
    // edge.
    task automatic step(input logic s, input logic v, input logic [7:0] d,
                        input logic iv, input logic [7:0] a);
        @(negedge clk);
        cfg_start = s;
        cfg_valid = v;
        cfg_data  = d;
        in_valid  = iv;
        in_data   = a;
        m_ov   = iv && m_done;
        m_miss = iv && !m_done;
        if (iv && m_done) m_od = m_tbl[a];
        if (s) begin
            m_loading = 1;
            m_done    = 0;
            m_beats   = 0;
        end else if (m_loading && v) begin
            for (int j = 0; j < CFG_W; j++) m_tbl[m_beats*CFG_W + j] = d[j];
            m_beats++;
            if (m_beats == c_B) begin
                m_loading = 0;
                m_done    = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid",   32'(out_valid),   32'(m_ov));
        chk("lookup_miss", 32'(lookup_miss), 32'(m_miss));
        chk("out_data",    32'(out_data),    32'(m_od));
        chk("cfg_ready",   32'(cfg_ready),   32'(m_loading));
        chk("cfg_done",    32'(cfg_done),    32'(m_done));
    endtask

    task automatic idle_inputs();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
    endtask

    // Assert reset away from any clock edge and check that the outputs drop
    // without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk({tag, "_rst_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, "_rst_done"},  32'(cfg_done),  32'd0);
        chk({tag, "_rst_ovalid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_const(input logic [7:0] d);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < c_B; i++) step(1'b0, 1'b1, d, 1'b0, 8'h00);
    endtask

    task automatic run_vectors(input string tag, input vec_t vecs [4]);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, vecs[i].addr);
            chk({tag, "_vec_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_vec_data"},  32'(out_data),  32'(vecs[i].exp));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk({tag, "_vec_idle"}, 32'(out_valid), 32'd0);
        chk({tag, "_vec_hold"}, 32'(out_data),  32'(vecs[3].exp));
    endtask

    initial begin
        vec_a5[0] = '{addr: 8'd0,   exp: 1'b1};
        vec_a5[1] = '{addr: 8'd1,   exp: 1'b0};
        vec_a5[2] = '{addr: 8'd2,   exp: 1'b1};
        vec_a5[3] = '{addr: 8'd255, exp: 1'b1};
        vec_k[0]  = '{addr: 8'd8,   exp: 1'b1};
        vec_k[1]  = '{addr: 8'd9,   exp: 1'b0};
        vec_k[2]  = '{addr: 8'd10,  exp: 1'b0};
        vec_k[3]  = '{addr: 8'd248, exp: 1'b1};

        // Reset state.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid),   32'd0);
        chk("reset_out_data",  32'(out_data),    32'd0);
        chk("reset_ready",     32'(cfg_ready),   32'd0);
        chk("reset_done",      32'(cfg_done),    32'd0);
        chk("reset_miss",      32'(lookup_miss), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lookup in EMPTY misses; a beat outside LOAD is ignored.
        step(1'b0, 1'b1, 8'hFF, 1'b1, 8'h40);
        chk("empty_miss",  32'(lookup_miss), 32'd1);
        chk("empty_valid", 32'(out_valid),   32'd0);

        // Full load of 8'hA5, cfg_done exactly after the last beat.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < c_B; i++) begin
            step(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
            chk("full_done_timing", 32'(cfg_done), (i == c_B - 1) ? 32'd1 : 32'd0);
        end
        run_vectors("a5", vec_a5);

        // Gapped stream of the same beats, plus a lookup during load.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 2 * c_B - 1; i++) begin
            step(1'b0, (i % 2) == 0, 8'hA5, (i == 19), 8'h40);
            if (i == 19) chk("load_miss", 32'(lookup_miss), 32'd1);
            chk("gap_done_timing", 32'(cfg_done), (i == 2 * c_B - 2) ? 32'd1 : 32'd0);
        end
        run_vectors("gap", vec_a5);

        // Restart mid-load: the beat presented with cfg_start is discarded.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00);
        for (int i = 0; i < c_B; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        chk("restart_done", 32'(cfg_done), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd0);
        chk("restart_lut0", 32'(out_data), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd100);
        chk("restart_lut100", 32'(out_data), 32'd0);

        // Reset with out_valid high clears it immediately.
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd5);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        async_reset("ov");

        // Reset mid-load, then lookups miss until a new full load.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        async_reset("midload");
        step(1'b0, 1'b1, 8'h3C, 1'b1, 8'h07);
        chk("post_rst_miss", 32'(lookup_miss), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < c_B; i++) begin
            step(1'b0, 1'b1, 8'(i), (i == c_B - 1), 8'h07);
            if (i == c_B - 1) chk("last_beat_miss", 32'(lookup_miss), 32'd1);
        end
        run_vectors("k", vec_k);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                 8'($urandom), $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
